aes128_stream_controller: RTL and testbench

- Byte-stream front end for the AES-128 decrypt core. Sits directly upstream of it and also consumes its result.
- Assembles a 16-byte key and a 16-byte ciphertext from an 8-bit valid/ready input stream.
- Presents the key and ciphertext to the core with decEnable, and waits a fixed CORE_LATENCY cycles because the core's completion flag is not usable.
- Captures opRetValue, then streams the 16 plaintext bytes out on an 8-bit valid/ready output.

---
 rtl/aes128_pkg.sv | 16 +
 rtl/aes128_byte_shifter.sv | 45 ++++
 rtl/aes128_stream_controller.sv | 173 +++++++++++++++++
 tb/tb_aes128_stream_controller.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes128_pkg.sv
// Shared constants and state encoding for the AES-128 byte-stream front end.
package aes128_pkg;

    localparam int AES_BLOCK_BYTES = 16;
    localparam int BYTE_CNT_W      = 4;
    localparam int WAIT_CNT_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_KEY  = 3'd1,
        ST_LOAD_DATA = 3'd2,
        ST_RUN       = 3'd3,
        ST_DRAIN     = 3'd4
    } state_t;

endpackage

// File: rtl/aes128_byte_shifter.sv
// 128-bit byte-lane register: synchronous clear, shift a byte in at the LSB
// end (older bytes move toward the MSB), parallel load, MSB byte out.
module aes128_byte_shifter
    import aes128_pkg::*;
(
    input  logic         clk,
    input  logic         srst,
    input  logic         i_shift_en,
    input  logic [7:0]   i_shift_byte,
    input  logic         i_load_en,
    input  logic [127:0] i_load_data,
    output logic [127:0] o_data,
    output logic [7:0]   o_msb_byte
);

    logic [127:0] r_data;
    logic [127:0] w_shifted;

    // Lane gi (0 = MSB lane) takes the contents of the lane below it; the
    // lowest lane takes the incoming byte.
    generate
        for (genvar gi = 0; gi < AES_BLOCK_BYTES; gi++) begin : g_lane
            if (gi == AES_BLOCK_BYTES - 1) begin : g_tail
                assign w_shifted[127-8*gi -: 8] = i_shift_byte;
            end else begin : g_body
                assign w_shifted[127-8*gi -: 8] = r_data[119-8*gi -: 8];
            end
        end
    endgenerate

    // Register update: clear wins, then parallel load, then shift.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_data <= '0;
        end else if (i_load_en) begin
            r_data <= i_load_data;
        end else if (i_shift_en) begin
            r_data <= w_shifted;
        end
    end

    assign o_data     = r_data;
    assign o_msb_byte = r_data[127:120];

endmodule

// File: rtl/aes128_stream_controller.sv
// Byte-stream front end for the AES-128 decrypt core: gathers key and
// ciphertext bytes, holds decEnable for a fixed latency, captures the
// result and streams the plaintext back out byte by byte.
module aes128_stream_controller
    import aes128_pkg::*;
#(
    parameter int CORE_LATENCY = 10
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [7:0]   in_byte,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         key_hold,
    output logic [7:0]   out_byte,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         decEnable,
    output logic [127:0] keyToOperate,
    output logic [127:0] dataToOperate,
    input  logic [127:0] opRetValue,
    output logic         key_loaded,
    busy
);

    state_t                r_state;
    state_t                w_state_next;
    logic [BYTE_CNT_W-1:0] r_byte_cnt;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic                  r_key_loaded;

    logic w_key_shift;
    logic w_data_shift;
    logic w_out_load;
    logic w_out_shift;
    logic w_xfer;
    logic w_last_byte;
    logic w_run_done;

    assign w_last_byte = (r_byte_cnt == BYTE_CNT_W'(AES_BLOCK_BYTES - 1));
    assign w_run_done  = (r_wait_cnt == WAIT_CNT_W'(1));
    assign w_xfer      = w_key_shift | w_data_shift | w_out_shift;
    assign key_loaded  = r_key_loaded;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-state handshake/enable decode.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        decEnable    = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        w_key_shift  = 1'b0;
        w_data_shift = 1'b0;
        w_out_load   = 1'b0;
        w_out_shift  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_next = (key_hold && r_key_loaded) ? ST_LOAD_DATA : ST_LOAD_KEY;
            end
            ST_LOAD_KEY: begin
                in_ready    = 1'b1;
                w_key_shift = in_valid;
                if (in_valid && w_last_byte) begin
                    w_state_next = ST_LOAD_DATA;
                end
            end
            ST_LOAD_DATA: begin
                in_ready     = 1'b1;
                w_data_shift = in_valid;
                if (in_valid && w_last_byte) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                decEnable = 1'b1;
                busy      = 1'b1;
                if (w_run_done) begin
                    w_out_load   = 1'b1;
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                out_valid   = 1'b1;
                busy        = 1'b1;
                w_out_shift = out_ready;
                if (out_ready && w_last_byte) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Byte counter: advances only on a handshake; 4-bit wrap lands on 0
    // exactly at the 16th transfer, which is also the phase change.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_byte_cnt <= '0;
        end else if (w_xfer) begin
            r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);
        end
    end

    // Wait counter: armed by the last ciphertext byte, counts down in RUN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wait_cnt <= '0;
        end else if (w_data_shift && w_last_byte) begin
            r_wait_cnt <= WAIT_CNT_W'(CORE_LATENCY);
        end else if (r_state == ST_RUN) begin
            r_wait_cnt <= r_wait_cnt - WAIT_CNT_W'(1);
        end
    end

    // Key-valid flag: dropped when a new key starts, set when it completes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_key_loaded <= 1'b0;
        end else if (w_key_shift) begin
            if (r_byte_cnt == '0) begin
                r_key_loaded <= 1'b0;
            end
            if (w_last_byte) begin
                r_key_loaded <= 1'b1;
            end
        end
    end

    aes128_byte_shifter u_key_shifter (
        .clk          (CLK),
        .srst         (RST),
        .i_shift_en   (w_key_shift),
        .i_shift_byte (in_byte),
        .i_load_en    (1'b0),
        .i_load_data  (128'd0),
        .o_data       (keyToOperate),
        .o_msb_byte   ()
    );

    aes128_byte_shifter u_data_shifter (
        .clk          (CLK),
        .srst         (RST),
        .i_shift_en   (w_data_shift),
        .i_shift_byte (in_byte),
        .i_load_en    (1'b0),
        .i_load_data  (128'd0),
        .o_data       (dataToOperate),
        .o_msb_byte   ()
    );

    aes128_byte_shifter u_out_shifter (
        .clk          (CLK),
        .srst         (RST),
        .i_shift_en   (w_out_shift),
        .i_shift_byte (8'h00),
        .i_load_en    (w_out_load),
        .i_load_data  (opRetValue),
        .o_data       (),
        .o_msb_byte   (out_byte)
    );

endmodule

// File: tb/tb_aes128_stream_controller.sv
// Bench for the AES-128 stream controller with a behavioural core model.
module tb_aes128_stream_controller;

    localparam int CL = 10;
    localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;

    logic         CLK = 1'b0;
    logic         RST;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_ready;
    logic         key_hold;
    logic [7:0]   out_byte;
    logic         out_valid;
    logic         out_ready;
    logic         decEnable;
    logic [127:0] keyToOperate;
    logic [127:0] dataToOperate;
    logic [127:0] opRetValue;
    logic         key_loaded;
    logic         busy;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           core_cnt = 0;
    logic [127:0] held_key = '0;

    always #5 CLK = ~CLK;

    aes128_stream_controller #(.CORE_LATENCY(CL)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .in_byte       (in_byte),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .key_hold      (key_hold),
        .out_byte      (out_byte),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .decEnable     (decEnable),
        .keyToOperate  (keyToOperate),
        .dataToOperate (dataToOperate),
        .opRetValue    (opRetValue),
        .key_loaded    (key_loaded),
        .busy          (busy)
    );

    // Stand-in core: knows the FIPS-197 vector, otherwise a keyed mix.
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d);
        if (k == FIPS_K && d == FIPS_C) return FIPS_P;
        return k ^ {d[63:0], d[127:64]} ^ 128'h5a5a_0f0f_a5a5_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    // Result is only correct during the final enable cycle; otherwise inverted.
    always @(posedge CLK) core_cnt <= decEnable ? core_cnt + 1 : 0;
    assign opRetValue = (decEnable && core_cnt == CL - 1) ? core_fn(keyToOperate, dataToOperate)
                                                          : ~core_fn(keyToOperate, dataToOperate);

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Feed n bytes MSB-first with optional random idle gaps; called at a negedge.
    task automatic send_bytes(input logic [127:0] v, input int n, input int gap_max, input bit is_key);
        for (int i = 0; i < n; i++) begin
            int t;
            if (gap_max > 0) begin
                int g;
                g = $urandom_range(0, gap_max);
                repeat (g) begin
                    in_valid = 1'b0;
                    in_byte  = 8'($urandom);
                    @(negedge CLK);
                end
            end
            in_byte  = v[127-8*i -: 8];
            in_valid = 1'b1;
            t = 0;
            while (!in_ready && t < 200) begin
                @(negedge CLK);
                t++;
            end
            n_tests++;
            if (t >= 200) begin
                n_fail++;
                $display("FAIL in_ready_timeout byte=%0d got in_ready=%b want 1", i, in_ready);
                in_valid = 1'b0;
                return;
            end
            @(negedge CLK);
            if (is_key && i == 0) begin
                n_tests++;
                if (key_loaded !== 1'b0) begin
                    n_fail++;
                    $display("FAIL key_loaded_clear got %b want 0", key_loaded);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    // One full block: optional key, ciphertext, RUN timing, DRAIN collection.
    task automatic run_block(input logic [127:0] k, input logic [127:0] d, input bit send_key,
                             input int gap, input bit toggle, input string tag);
        logic [127:0] exp_key, exp_pt, got, prev_byte;
        int dec_cycles, lat, n, t;
        bit bad_stable, bad_hold, bad_valid, prev_stall;
        exp_key = send_key ? k : held_key;
        exp_pt  = core_fn(exp_key, d);
        if (send_key) begin
            send_bytes(k, 16, gap, 1'b1);
            n_tests++;
            if (keyToOperate !== k) begin
                n_fail++;
                $display("FAIL %s key_reg got %h want %h", tag, keyToOperate, k);
            end
            n_tests++;
            if (key_loaded !== 1'b1) begin
                n_fail++;
                $display("FAIL %s key_loaded got %b want 1", tag, key_loaded);
            end
        end
        send_bytes(d, 16, gap, 1'b0);
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s in_ready_after_16 got %b want 0", tag, in_ready);
        end
        dec_cycles = 0;
        lat = 0;
        bad_stable = 0;
        while (!out_valid && lat < CL + 50) begin
            if (decEnable) dec_cycles++;
            if (keyToOperate !== exp_key || dataToOperate !== d || busy !== 1'b1) bad_stable = 1;
            @(negedge CLK);
            lat++;
        end
        n_tests++;
        if (dec_cycles != CL) begin
            n_fail++;
            $display("FAIL %s decEnable_cycles got %0d want %0d", tag, dec_cycles, CL);
        end
        n_tests++;
        if (lat != CL) begin
            n_fail++;
            $display("FAIL %s first_out_latency got %0d want %0d", tag, lat, CL);
        end
        n_tests++;
        if (bad_stable) begin
            n_fail++;
            $display("FAIL %s run_operands got key=%h data=%h want key=%h data=%h",
                     tag, keyToOperate, dataToOperate, exp_key, d);
        end
        got = '0;
        prev_byte = '0;
        n = 0;
        t = 0;
        bad_hold = 0;
        bad_valid = 0;
        prev_stall = 0;
        while (n < 16 && t < 400) begin
            if (!out_valid) bad_valid = 1;
            if (prev_stall && out_byte !== prev_byte[7:0]) bad_hold = 1;
            out_ready = toggle ? t[0] : 1'b1;
            if (out_ready) begin
                got = {got[119:0], out_byte};
                n++;
                prev_stall = 0;
            end else begin
                prev_stall = 1;
                prev_byte  = {120'd0, out_byte};
            end
            @(negedge CLK);
            t++;
        end
        out_ready = 1'b0;
        n_tests++;
        if (n != 16 || bad_valid || bad_hold) begin
            n_fail++;
            $display("FAIL %s drain_handshake got n=%0d valid_drop=%b hold_err=%b want 16/0/0",
                     tag, n, bad_valid, bad_hold);
        end
        n_tests++;
        if (got !== exp_pt) begin
            n_fail++;
            $display("FAIL %s plaintext got %h want %h", tag, got, exp_pt);
        end
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_after_drain got valid=%b busy=%b in_ready=%b want 0/0/0",
                     tag, out_valid, busy, in_ready);
        end
        held_key = exp_key;
        $display("[TB] block %s key=%h ct=%h pt=%h", tag, exp_key, d, got);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        held_key = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({in_ready, out_valid, decEnable, busy, out_byte, keyToOperate, dataToOperate} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got rdy=%b ov=%b de=%b busy=%b ob=%h k=%h d=%h want all 0",
                     in_ready, out_valid, decEnable, busy, out_byte, keyToOperate, dataToOperate);
        end
        n_tests++;
        if (key_loaded !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_key_loaded got %b want 0", key_loaded);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_fips();
        key_hold = 1'b0;
        run_block(FIPS_K, FIPS_C, 1'b1, 0, 1'b0, "fips");
    endtask

    task automatic test_key_hold();
        key_hold = 1'b1;
        run_block(rand128(), FIPS_C, 1'b0, 0, 1'b0, "hold_fips");
        run_block(rand128(), rand128(), 1'b0, 2, 1'b0, "hold_rand");
        key_hold = 1'b0;
    endtask

    task automatic test_back_pressure();
        key_hold = 1'b0;
        run_block(rand128(), rand128(), 1'b1, 0, 1'b1, "toggle_rand");
        run_block(FIPS_K, FIPS_C, 1'b1, 0, 1'b1, "toggle_fips");
    endtask

    task automatic test_gaps();
        key_hold = 1'b0;
        run_block(FIPS_K, FIPS_C, 1'b1, 3, 1'b0, "gaps_fips");
        for (int r = 0; r < 3; r++) begin
            run_block(rand128(), rand128(), 1'b1, 4, r[0], "gaps_rand");
        end
    endtask

    task automatic test_reset_mid();
        key_hold = 1'b0;
        send_bytes(FIPS_K, 16, 0, 1'b1);
        send_bytes(FIPS_C, 7, 0, 1'b0);
        RST = 1'b1;
        @(negedge CLK);
        n_tests++;
        if ({in_ready, out_valid, decEnable, busy, out_byte, keyToOperate, dataToOperate} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs got rdy=%b ov=%b de=%b busy=%b ob=%h k=%h d=%h want all 0",
                     in_ready, out_valid, decEnable, busy, out_byte, keyToOperate, dataToOperate);
        end
        n_tests++;
        if (key_loaded !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_key_loaded got %b want 0", key_loaded);
        end
        RST = 1'b0;
        held_key = '0;
        key_hold = 1'b1;
        run_block(FIPS_K, FIPS_C, 1'b1, 0, 1'b0, "after_midreset");
        key_hold = 1'b0;
    endtask

    task automatic test_hold_after_reset();
        do_reset();
        key_hold = 1'b1;
        run_block(rand128(), rand128(), 1'b1, 1, 1'b0, "hold_after_reset");
        key_hold = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        in_byte = 8'h00;
        in_valid = 1'b0;
        key_hold = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_fips();
        test_key_hold();
        test_back_pressure();
        test_gaps();
        test_reset_mid();
        test_hold_after_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
